serial_scan_ctrl: RTL

- Single timing engine that sequences the panel's 74LV595 output chains and 74LV165 input chains together, frame by frame.
- Each frame does the following, in order:
  - captures a coherent snapshot of the four outgoing 16-bit words;
  - parallel-loads the input chains;
  - shifts 16 bits out and 16 bits in on a shared serial clock;
  - latches the outputs and publishes the four incoming words with a valid strobe.
- Sits between the core/panel logic and the board shift-register pins.
- Frames repeat automatically, separated by a configurable gap; a request input forces an early frame.

---
 rtl/serial_scan_ctrl_if.sv | 45 ++++
 rtl/serial_scan_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/serial_scan_ctrl_if.sv
// Core-side and board-pin signals of the scan-chain sequencer, bundled for port hookup.
// Latency: none, wiring only.
// Backpressure: none; the slave modport is the sequencer, the master is core logic plus board pins.
interface serial_scan_ctrl_if #(
    parameter int NBITS = 16
);
    logic             enable;
    logic             frame_req;
    logic [NBITS-1:0] out_data_0;
    logic [NBITS-1:0] out_data_1;
    logic [NBITS-1:0] out_data_2;
    logic [NBITS-1:0] out_data_3;
    logic [NBITS-1:0] in_data_0;
    logic [NBITS-1:0] in_data_1;
    logic [NBITS-1:0] in_data_2;
    logic [NBITS-1:0] in_data_3;
    logic             in_valid;
    logic             busy;
    logic [7:0]       frame_cnt;
    logic             SRCLK;
    logic             RCLK;
    logic             SH_LDn;
    logic             SER_0;
    logic             SER_1;
    logic             SER_2;
    logic             SER_3;
    logic             QH_0;
    logic             QH_1;
    logic             QH_2;
    logic             QH_3;

    modport master (
        output enable, frame_req, out_data_0, out_data_1, out_data_2, out_data_3,
        output QH_0, QH_1, QH_2, QH_3,
        input  in_data_0, in_data_1, in_data_2, in_data_3, in_valid, busy, frame_cnt,
        input  SRCLK, RCLK, SH_LDn, SER_0, SER_1, SER_2, SER_3
    );

    modport slave (
        input  enable, frame_req, out_data_0, out_data_1, out_data_2, out_data_3,
        input  QH_0, QH_1, QH_2, QH_3,
        output in_data_0, in_data_1, in_data_2, in_data_3, in_valid, busy, frame_cnt,
        output SRCLK, RCLK, SH_LDn, SER_0, SER_1, SER_2, SER_3
    );
endinterface

// File: rtl/serial_scan_ctrl.sv
// Frame sequencer driving four 74LV595 output chains and four 74LV165 input chains on one SRCLK.
// Latency: 34*DIV clk cycles from LOAD entry to the in_valid cycle; GAP+1 idle cycles between automatic frames.
// Backpressure: none; frame_req seen while busy is held in one pending bit and served on return to idle.
module serial_scan_ctrl #(
    parameter int DIV   = 2,
    parameter int GAP   = 64,
    parameter int NBITS = 16
) (
    input  logic              clk,
    input  logic              resetn,
    serial_scan_ctrl_if.slave bus
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GW = $clog2(GAP + 1);
    localparam int IW = $clog2(NBITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP);
    localparam logic [IW-1:0] IDX_MSB  = IW'(NBITS - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [IW-1:0]    idx;
    logic [GW-1:0]    gap;
    logic             pending;
    logic [7:0]       frame_cnt;
    logic [NBITS-1:0] out_word [4];
    logic [NBITS-1:0] out_sr   [4];
    logic [NBITS-1:0] in_sr    [4];
    logic [NBITS-1:0] in_q     [4];
    logic [3:0]       qh;
    logic [3:0]       ser;
    logic             last;
    logic             start;
    logic             in_valid;

    assign out_word[0] = bus.out_data_0;
    assign out_word[1] = bus.out_data_1;
    assign out_word[2] = bus.out_data_2;
    assign out_word[3] = bus.out_data_3;
    assign qh = {bus.QH_3, bus.QH_2, bus.QH_1, bus.QH_0};

    // Every non-idle state lasts DIV cycles; last marks the final one.
    assign last  = (cnt == CNT_LAST);
    // A frame launches from idle on an explicit or remembered request, or when the gap has run out.
    assign start = (state == IDLE) && (bus.frame_req || pending || (bus.enable && gap == '0));

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state: LOAD, then 16 low/high SRCLK periods MSB first, then LATCH back to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = LOAD;
            LOAD:     if (last)  state_nxt = SHIFT_LO;
            SHIFT_LO: if (last)  state_nxt = SHIFT_HI;
            SHIFT_HI: if (last)  state_nxt = (idx == '0) ? LATCH : SHIFT_LO;
            LATCH:    if (last)  state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    // Pin and strobe decode; everything is a function of registered state so reset clears it at once.
    always_comb begin
        bus.busy   = (state != IDLE);
        bus.SRCLK  = (state == SHIFT_HI);
        bus.RCLK   = (state == LATCH);
        bus.SH_LDn = (state != LOAD);
        in_valid   = (state == LATCH) && last;
        ser        = '0;
        if (state == SHIFT_LO || state == SHIFT_HI) begin
            for (int k = 0; k < 4; k++) ser[k] = out_sr[k][idx];
        end
    end

    assign bus.SER_0     = ser[0];
    assign bus.SER_1     = ser[1];
    assign bus.SER_2     = ser[2];
    assign bus.SER_3     = ser[3];
    assign bus.in_valid  = in_valid;
    assign bus.frame_cnt = frame_cnt;
    // New words appear in the in_valid cycle itself, then stay held until the next frame publishes.
    assign bus.in_data_0 = in_valid ? in_sr[0] : in_q[0];
    assign bus.in_data_1 = in_valid ? in_sr[1] : in_q[1];
    assign bus.in_data_2 = in_valid ? in_sr[2] : in_q[2];
    assign bus.in_data_3 = in_valid ? in_sr[3] : in_q[3];

    // Phase timer, bit index, request memory and inter-frame gap.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt     <= '0;
            idx     <= '0;
            pending <= 1'b0;
            gap     <= '0;
        end else begin
            cnt <= (state != IDLE && !last) ? cnt + CW'(1) : '0;
            if (start) idx <= IDX_MSB;
            else if (state == SHIFT_HI && last && idx != '0) idx <= idx - IW'(1);
            if (start) pending <= 1'b0;
            else if (bus.frame_req && state != IDLE) pending <= 1'b1;
            if (state == LATCH && last) gap <= GAP_LOAD;
            else if (state == IDLE && gap != '0) gap <= gap - GW'(1);
        end
    end

    // Chain shift registers: out words snapshot once at frame launch, QH sampled at end of each low phase.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int k = 0; k < 4; k++) begin
                out_sr[k] <= '0;
                in_sr[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (start) out_sr[k] <= out_word[k];
                if (state == SHIFT_LO && last) in_sr[k] <= {in_sr[k][NBITS-2:0], qh[k]};
            end
        end
    end

    // Publish captured words and count completed frames.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int k = 0; k < 4; k++) in_q[k] <= '0;
            frame_cnt <= '0;
        end else if (in_valid) begin
            for (int k = 0; k < 4; k++) in_q[k] <= in_sr[k];
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
endmodule
